// File: rtl/shift_pkg.sv
// Shared decode constants, op-select encoding and shift helpers for the
// RV32I shift issue stage.
package shift_pkg;

  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SRA  = 7'h20;

  typedef enum logic [1:0] {
    SLL = 2'd0,
    SRL = 2'd1,
    SRA = 2'd2,
    ILL = 2'd3
  } op_sel_e;

  // Shifter modes per instance slot: slot0 logical-left, slot1 logical-right, slot2 arithmetic-right
  localparam logic [5:0] SHIFT_MODES = {2'd3, 2'd2, 2'd0};

  typedef struct packed {
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        op_imm;
    logic        imm_hi;
    logic [4:0]  shamt;
    logic [31:0] rs1;
    logic [4:0]  rd;
  } s1_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        illegal;
  } s2_t;

  function automatic op_sel_e decode_op(input logic [2:0] funct3, input logic [6:0] funct7,
                                        input logic op_imm, input logic imm_hi);
    op_sel_e op;
    op = ILL;
    // RV32 immediates cannot encode a 6-bit shamt
    if (!(op_imm && imm_hi)) begin
      if (funct3 == F3_SLL && funct7 == F7_BASE)     op = SLL;
      else if (funct3 == F3_SR && funct7 == F7_BASE) op = SRL;
      else if (funct3 == F3_SR && funct7 == F7_SRA)  op = SRA;
    end
    return op;
  endfunction

  function automatic logic [31:0] shift32(input logic [31:0] data, input logic [4:0] amt,
                                          input logic [1:0] mode);
    logic [31:0] r;
    case (mode)
      2'd0:    r = data << amt;
      2'd2:    r = data >> amt;
      2'd3:    r = $signed(data) >>> amt;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_pipe_reg.sv
// Valid/data pipeline register slice with advance enable and flush.
module shift_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         adv_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (adv_i) begin
      valid_d = valid_i;
      // Payload only moves with a valid beat so a stalled output stays stable
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/shift_issue_stage.sv
// Two-stage RV32I shift front-end: S1 registers the decoded fields, S2
// registers the selected shifter result. Valid/ready on both sides.
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic             in_op_imm,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [5:0]       in_imm,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic             s1_valid, s2_valid, s1_adv, s2_adv;
  logic [CNT_W-1:0] count_d, count_q;
  op_sel_e          op_sel;
  logic [31:0]      shift_res [3];
  logic             rs2_unused;

  assign rs2_unused = ^in_rs2[31:5];

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = flush || !s1_valid || s1_adv;

  always_comb begin
    s1_d        = '0;
    s1_d.funct3 = in_funct3;
    s1_d.funct7 = in_funct7;
    s1_d.op_imm = in_op_imm;
    s1_d.imm_hi = in_imm[5];
    s1_d.shamt  = in_op_imm ? in_imm[4:0] : in_rs2[4:0];
    s1_d.rs1    = in_rs1;
    s1_d.rd     = in_rd;
  end

  shift_pipe_reg #(.W($bits(s1_t))) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .adv_i   (in_ready),
    .valid_i (in_valid),
    .data_i  (s1_d),
    .valid_o (s1_valid),
    .data_o  (s1_q)
  );

  assign op_sel = decode_op(s1_q.funct3, s1_q.funct7, s1_q.op_imm, s1_q.imm_hi);

  for (genvar gi = 0; gi < 3; gi++) begin : g_shift
    assign shift_res[gi] = shift32(s1_q.rs1, s1_q.shamt, SHIFT_MODES[gi*2 +: 2]);
  end

  always_comb begin
    s2_d    = '0;
    s2_d.rd = s1_q.rd;
    case (op_sel)
      SLL:     s2_d.result = shift_res[0];
      SRL:     s2_d.result = shift_res[1];
      SRA:     s2_d.result = shift_res[2];
      default: s2_d.illegal = 1'b1;
    endcase
  end

  shift_pipe_reg #(.W($bits(s2_t))) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .adv_i   (s2_adv),
    .valid_i (s1_valid),
    .data_i  (s2_d),
    .valid_o (s2_valid),
    .data_o  (s2_q)
  );

  // A flushed cycle is not a delivered result, even if out_ready was high
  assign count_d = (s2_valid && out_ready && !flush) ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign out_valid   = s2_valid;
  assign out_result  = s2_q.result;
  assign out_rd      = s2_q.rd;
  assign out_illegal = s2_q.illegal;
  assign op_count    = count_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage: vector table, random stream with
// random backpressure, and hand-written reset/stall/flush/wrap sequences.
module tb_shift_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic        in_op_imm;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [5:0]  in_imm;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [15:0] op_count;

  shift_issue_stage #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct3   (in_funct3),
    .in_funct7   (in_funct7),
    .in_op_imm   (in_op_imm),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_illegal (out_illegal),
    .op_count    (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        oi;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  imm;
    logic [31:0] exp_res;
    logic        exp_ill;
  } vec_t;

  exp_t        sb[$];
  exp_t        cur_exp;
  int          checks;
  int          failures;
  logic [15:0] exp_count;
  bit          quiet;
  bit          rnd_done;
  vec_t        vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Reference: shifts built from a 64-bit sign-extended word, independent of the RTL helpers
  function automatic exp_t model(input logic [2:0] f3, input logic [6:0] f7, input logic oi,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [5:0] imm, input logic [4:0] rd);
    exp_t        e;
    logic [4:0]  amt;
    logic [63:0] w;
    bit          is_sll, is_srl, is_sra;
    amt    = oi ? imm[4:0] : rs2[4:0];
    is_sll = (f3 == 3'b001) && (f7 == 7'h00);
    is_srl = (f3 == 3'b101) && (f7 == 7'h00);
    is_sra = (f3 == 3'b101) && (f7 == 7'h20);
    if (oi && imm[5]) begin
      is_sll = 0; is_srl = 0; is_sra = 0;
    end
    e.rd  = rd;
    e.ill = !(is_sll || is_srl || is_sra);
    e.res = 32'h0;
    if (is_sll) e.res = rs1 << amt;
    if (is_srl) e.res = rs1 >> amt;
    if (is_sra) begin
      w     = {{32{rs1[31]}}, rs1};
      w     = w >> amt;
      e.res = w[31:0];
    end
    return e;
  endfunction

  // Scoreboard: pop/compare on out handshake, push on in handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        exp_count = 16'h0;
      end else if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          exp_count = exp_count + 16'h1;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual=0x%08h required=no_output", out_result);
          end else begin
            e = sb.pop_front();
            check("out_result", out_result, e.res);
            check("out_rd", {27'h0, out_rd}, {27'h0, e.rd});
            check("out_illegal", {31'h0, out_illegal}, {31'h0, e.ill});
          end
          if (!quiet)
            $display("OUT rd=%0d result=0x%08h illegal=%0b handshakes=%0d",
                     out_rd, out_result, out_illegal, exp_count);
        end
        if (in_valid && in_ready) sb.push_back(cur_exp);
      end
    end
  end

  task automatic drive(input logic [2:0] f3, input logic [6:0] f7, input logic oi,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [5:0] imm,
                       input exp_t e);
    in_funct3 = f3;
    in_funct7 = f7;
    in_op_imm = oi;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    in_rd     = e.rd;
    cur_exp   = e;
    in_valid  = 1'b1;
  endtask

  // Offers one op and returns at #1 after the accepting edge
  task automatic send(input logic [2:0] f3, input logic [6:0] f7, input logic oi,
                      input logic [31:0] rs1, input logic [31:0] rs2, input logic [5:0] imm,
                      input exp_t e);
    bit acc;
    acc = 0;
    drive(f3, f7, oi, rs1, rs2, imm, e);
    for (int c = 0; c < 80 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready && !flush && rst_n;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 300) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    exp_t e1, e;
    logic [15:0] base;
    int n, acc, guard;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] imm;
    logic       oi;
    logic [31:0] r1, r2;

    checks = 0; failures = 0; quiet = 0; rnd_done = 0; exp_count = 16'h0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_funct3 = '0; in_funct7 = '0; in_op_imm = 1'b0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_rd = '0; cur_exp = '0;

    vecs[0]  = '{3'b001, 7'h00, 1'b0, 32'h0000_0001, 32'd31,        6'd0,  32'h8000_0000, 1'b0};
    vecs[1]  = '{3'b101, 7'h20, 1'b1, 32'h8000_0010, 32'd0,         6'd4,  32'hF800_0001, 1'b0};
    vecs[2]  = '{3'b101, 7'h00, 1'b1, 32'h8000_0010, 32'd0,         6'd4,  32'h0800_0001, 1'b0};
    vecs[3]  = '{3'b101, 7'h20, 1'b1, 32'h8000_0010, 32'd0,         6'd0,  32'h8000_0010, 1'b0};
    vecs[4]  = '{3'b001, 7'h00, 1'b1, 32'h0000_0001, 32'd0,         6'h21, 32'h0000_0000, 1'b1};
    vecs[5]  = '{3'b001, 7'h20, 1'b0, 32'h0000_0001, 32'd1,         6'd0,  32'h0000_0000, 1'b1};
    vecs[6]  = '{3'b101, 7'h20, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 6'd0,  32'hFFFF_FFFF, 1'b0};
    vecs[7]  = '{3'b001, 7'h00, 1'b0, 32'h1234_5676, 32'h0000_003F, 6'd0,  32'h0000_0000, 1'b0};
    vecs[8]  = '{3'b001, 7'h00, 1'b0, 32'h1234_5677, 32'd31,        6'd0,  32'h8000_0000, 1'b0};
    vecs[9]  = '{3'b101, 7'h00, 1'b0, 32'h8000_0000, 32'd31,        6'd0,  32'h0000_0001, 1'b0};
    vecs[10] = '{3'b000, 7'h00, 1'b0, 32'h0000_00FF, 32'd1,         6'd0,  32'h0000_0000, 1'b1};
    vecs[11] = '{3'b101, 7'h00, 1'b0, 32'hDEAD_BEEF, 32'h0000_0020, 6'd0,  32'hDEAD_BEEF, 1'b0};
    vecs[12] = '{3'b001, 7'h00, 1'b1, 32'h0000_000F, 32'd0,         6'd4,  32'h0000_00F0, 1'b0};
    vecs[13] = '{3'b101, 7'h01, 1'b0, 32'h8000_0000, 32'd1,         6'd0,  32'h0000_0000, 1'b1};
    vecs[14] = '{3'b101, 7'h20, 1'b0, 32'h7FFF_FFFF, 32'd31,        6'd0,  32'h0000_0000, 1'b0};
    vecs[15] = '{3'b101, 7'h20, 1'b1, 32'h8000_0000, 32'd0,         6'h23, 32'h0000_0000, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("rst_op_count", {16'h0, op_count}, 32'd0);

    // Reset in the middle of a stream
    for (int i = 0; i < 3; i++)
      send(3'b001, 7'h00, 1'b0, 32'(i + 1), 32'(i), 6'd0,
           model(3'b001, 7'h00, 1'b0, 32'(i + 1), 32'(i), 6'd0, 5'(i + 1)));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'h0, out_valid}, 32'd0);
    check("midrst_op_count", {16'h0, op_count}, 32'd0);
    check("midrst_in_ready", {31'h0, in_ready}, 32'd1);
    check("midrst_out_result", out_result, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Two-cycle latency from the handshake cycle
    send(3'b001, 7'h00, 1'b0, 32'h1, 32'd31, 6'd0, '{32'h8000_0000, 5'd7, 1'b0});
    check("lat_cycle1_out_valid", {31'h0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_cycle2_out_valid", {31'h0, out_valid}, 32'd1);
    check("lat_cycle2_result", out_result, 32'h8000_0000);
    drain();

    // Vector table, back to back
    for (int i = 0; i < 16; i++) begin
      e.res = vecs[i].exp_res;
      e.rd  = 5'(10 + i);
      e.ill = vecs[i].exp_ill;
      send(vecs[i].f3, vecs[i].f7, vecs[i].oi, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, e);
    end
    drain();
    check("table_op_count", {16'h0, op_count}, {16'h0, exp_count});

    // Random ops under random backpressure
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          case ($urandom_range(0, 3))
            0:       f3 = 3'b001;
            1, 2:    f3 = 3'b101;
            default: f3 = 3'($urandom);
          endcase
          case ($urandom_range(0, 4))
            0, 1:    f7 = 7'h00;
            2, 3:    f7 = 7'h20;
            default: f7 = 7'($urandom);
          endcase
          oi  = 1'($urandom_range(0, 1));
          imm = {($urandom_range(0, 7) == 0), 5'($urandom)};
          r1  = $urandom;
          r2  = $urandom;
          send(f3, f7, oi, r1, r2, imm, model(f3, f7, oi, r1, r2, imm, 5'(i)));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("random_op_count", {16'h0, op_count}, {16'h0, exp_count});

    // Backpressure: two accepts fill the pipe, outputs hold for 5 cycles
    base = exp_count;
    out_ready = 1'b0;
    e1 = model(3'b001, 7'h00, 1'b0, 32'hA5A5_0001, 32'd3, 6'd0, 5'd21);
    send(3'b001, 7'h00, 1'b0, 32'hA5A5_0001, 32'd3, 6'd0, e1);
    send(3'b101, 7'h20, 1'b0, 32'h9000_0000, 32'd8, 6'd0,
         model(3'b101, 7'h20, 1'b0, 32'h9000_0000, 32'd8, 6'd0, 5'd22));
    drive(3'b101, 7'h00, 1'b1, 32'hFFFF_0000, 32'd0, 6'd12,
          model(3'b101, 7'h00, 1'b1, 32'hFFFF_0000, 32'd0, 6'd12, 5'd23));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_in_ready", {31'h0, in_ready}, 32'd0);
      check("stall_out_valid", {31'h0, out_valid}, 32'd1);
      check("stall_out_result", out_result, e1.res);
      check("stall_out_rd", {27'h0, out_rd}, {27'h0, e1.rd});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(3'b101, 7'h00, 1'b1, 32'hFFFF_0000, 32'd0, 6'd12,
         model(3'b101, 7'h00, 1'b1, 32'hFFFF_0000, 32'd0, 6'd12, 5'd23));
    send(3'b001, 7'h00, 1'b1, 32'h0000_0003, 32'd0, 6'd30,
         model(3'b001, 7'h00, 1'b1, 32'h0000_0003, 32'd0, 6'd30, 5'd24));
    drain();
    check("bp_op_count", {16'h0, op_count}, {16'h0, base + 16'd4});

    // Flush with both stages full, plus a discarded offer in the flush cycle
    base = exp_count;
    out_ready = 1'b0;
    send(3'b001, 7'h00, 1'b0, 32'h1, 32'd1, 6'd0, model(3'b001, 7'h00, 1'b0, 32'h1, 32'd1, 6'd0, 5'd1));
    send(3'b001, 7'h00, 1'b0, 32'h1, 32'd2, 6'd0, model(3'b001, 7'h00, 1'b0, 32'h1, 32'd2, 6'd0, 5'd2));
    drive(3'b001, 7'h00, 1'b0, 32'h1, 32'd3, 6'd0, model(3'b001, 7'h00, 1'b0, 32'h1, 32'd3, 6'd0, 5'd3));
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {31'h0, out_valid}, 32'd0);
    check("flush_op_count", {16'h0, op_count}, {16'h0, base});
    repeat (3) @(posedge clk);
    #1;
    check("flush_no_output", {31'h0, out_valid}, 32'd0);
    send(3'b101, 7'h20, 1'b0, 32'h8000_0000, 32'd4, 6'd0,
         model(3'b101, 7'h20, 1'b0, 32'h8000_0000, 32'd4, 6'd0, 5'd9));
    drain();
    check("post_flush_op_count", {16'h0, op_count}, {16'h0, base + 16'd1});

    // Counter wrap: stream up to 0xFFFF handshakes, then one more
    quiet = 1;
    n = 32'h0000_FFFF - int'(exp_count);
    acc = 0;
    guard = 0;
    drive(3'b001, 7'h00, 1'b0, 32'h5, 32'd1, 6'd0, model(3'b001, 7'h00, 1'b0, 32'h5, 32'd1, 6'd0, 5'd17));
    while (acc < n && guard < n + 100) begin
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1 guard++;
    end
    in_valid = 1'b0;
    drain();
    quiet = 0;
    check("wrap_pre_count", {16'h0, op_count}, 32'h0000_FFFF);
    send(3'b001, 7'h00, 1'b0, 32'h5, 32'd2, 6'd0, model(3'b001, 7'h00, 1'b0, 32'h5, 32'd2, 6'd0, 5'd18));
    drain();
    check("wrap_count", {16'h0, op_count}, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
